// File: rtl/loader_pkg.sv
// Shared definitions for the serial instruction-memory loader.
// Optional feature: define LOADER_CHECKSUM_EN to add the trailing checksum byte (CHK state).
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W    = 10;
    localparam int unsigned LOADER_MAX_WORDS = 1024;
    localparam int unsigned BYTES_PER_WORD   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        CHK    = 3'd5,
`endif
        DONE   = 3'd6
    } loader_state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_byte(input loader_state_e s);
        case (s)
            LEN_LO, LEN_HI, DATA: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                  return 1'b1;
`endif
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler: shifts bytes in from the top so the
// first byte of a word ends up in bits 7:0 and the fourth in bits 31:24.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0] byte_cnt;

    // Shift register and 0..3 byte position; clear drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            word     <= {data_byte, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Flags the shift that completes a word, so the next cycle can write it.
    always_comb begin
        word_complete = shift && (byte_cnt == LAST_BYTE);
    end

endmodule

// File: rtl/instrmem_loader.sv
// Serial program loader: reads a 16-bit little-endian word count followed by
// the program bytes, writes each assembled 32-bit word into instruction memory
// and releases the CPU reset once the load has finished.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module instrmem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = LOADER_ADDR_W,
    parameter int MAX_WORDS = LOADER_MAX_WORDS
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Start,
    input  logic [7:0]        i_Byte,
    input  logic              i_Byte_Valid,
    output logic              o_Byte_Ready,
    output logic [ADDR_W-1:0] o_InstrMEM_Write_Addr,
    output logic [31:0]       o_InstrMEM_Write_Instr,
    output logic              o_InstrMEM_MemWrite,
    output logic              o_CPU_RSTN,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error
);

    localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_DATA = CHK;
`else
    localparam loader_state_e AFTER_DATA = DONE;
`endif

    loader_state_e     state;
    loader_state_e     state_next;

    logic              xfer;
    logic              start_load;
    logic [7:0]        len_lo;
    logic [15:0]       len_full;
    logic              len_over;
    logic [15:0]       n_words;
    logic [15:0]       word_cnt;
    logic              last_word;
    logic [ADDR_W-1:0] addr;
    logic              error;
    logic [31:0]       asm_word;
    logic              word_complete;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_xor;
`endif

    // Handshake, length decode and end-of-load detection.
    always_comb begin
        xfer       = o_Byte_Ready && i_Byte_Valid;
        start_load = i_Start && ((state == IDLE) || (state == DONE));
        len_full   = {i_Byte, len_lo};
        len_over   = len_full > MAX_W16;
        last_word  = (word_cnt + 16'd1) == n_words;
    end

    // State register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_Start) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_next = (len_full != 16'd0) ? DATA : AFTER_DATA;
            end
            DATA: begin
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_word ? AFTER_DATA : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_next = DONE;
            end
`endif
            DONE: begin
                if (i_Start) state_next = LEN_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    // Length, word counter, write address, error flag and checksum accumulator.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            len_lo   <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            addr     <= '0;
            error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_xor  <= '0;
`endif
        end else if (start_load) begin
            n_words  <= '0;
            word_cnt <= '0;
            addr     <= '0;
            error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_xor  <= '0;
`endif
        end else begin
`ifdef LOADER_CHECKSUM_EN
            // The checksum covers the length header as well as the payload.
            if (xfer && (state != CHK)) chk_xor <= chk_xor ^ i_Byte;
`endif
            case (state)
                LEN_LO: begin
                    if (xfer) len_lo <= i_Byte;
                end
                LEN_HI: begin
                    if (xfer) begin
                        n_words <= len_over ? MAX_W16 : len_full;
                        if (len_over) error <= 1'b1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    // Address only advances when another word follows, so it never wraps.
                    if (!last_word) addr <= addr + ADDR_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer && (i_Byte != chk_xor)) error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    loader_word_assembler u_word_assembler (
        .clk           (i_CLK),
        .rst           (i_RST),
        .clear         (start_load),
        .shift         (xfer && (state == DATA)),
        .data_byte     (i_Byte),
        .word          (asm_word),
        .word_complete (word_complete)
    );

    // Outputs decoded from state plus the datapath registers.
    always_comb begin
        o_Byte_Ready           = accepts_byte(state);
        o_InstrMEM_Write_Addr  = addr;
        o_InstrMEM_Write_Instr = asm_word;
        o_InstrMEM_MemWrite    = (state == WRITE);
        o_CPU_RSTN             = (state == DONE);
        o_Busy                 = (state != IDLE) && (state != DONE);
        o_Done                 = (state == DONE);
        o_Error                = error;
    end

endmodule

// File: tb/tb_instrmem_loader.sv
// Scoreboard bench for instrmem_loader; build with +define+LOADER_CHECKSUM_EN
// to exercise the checksum variant.
module tb_instrmem_loader;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_Start;
    logic [7:0]  i_Byte;
    logic        i_Byte_Valid;
    logic        o_Byte_Ready;
    logic [9:0]  o_InstrMEM_Write_Addr;
    logic [31:0] o_InstrMEM_Write_Instr;
    logic        o_InstrMEM_MemWrite;
    logic        o_CPU_RSTN;
    logic        o_Busy;
    logic        o_Done;
    logic        o_Error;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks     = 0;
    int  failures   = 0;
    int  writes_seen = 0;

    instrmem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .i_CLK                  (i_CLK),
        .i_RST                  (i_RST),
        .i_Start                (i_Start),
        .i_Byte                 (i_Byte),
        .i_Byte_Valid           (i_Byte_Valid),
        .o_Byte_Ready           (o_Byte_Ready),
        .o_InstrMEM_Write_Addr  (o_InstrMEM_Write_Addr),
        .o_InstrMEM_Write_Instr (o_InstrMEM_Write_Instr),
        .o_InstrMEM_MemWrite    (o_InstrMEM_MemWrite),
        .o_CPU_RSTN             (o_CPU_RSTN),
        .o_Busy                 (o_Busy),
        .o_Done                 (o_Done),
        .o_Error                (o_Error)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a write strobe consumes one scoreboard entry.
    initial begin
        wr_t e;
        forever begin
            @(negedge i_CLK);
            if (o_InstrMEM_MemWrite === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write",
                             o_InstrMEM_Write_Addr, o_InstrMEM_Write_Instr);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(o_InstrMEM_Write_Addr), 32'(e.addr));
                    check("write_data", o_InstrMEM_Write_Instr, e.data);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge i_CLK);
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge i_CLK);
        i_Byte       = b;
        i_Byte_Valid = 1'b1;
        t = 0;
        while (!o_Byte_Ready && t < 50) begin
            @(negedge i_CLK);
            t++;
        end
        if (!o_Byte_Ready) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=ready low for 50 cycles required=ready high (byte 0x%0h)", b);
        end else begin
            @(posedge i_CLK);
            #1;
        end
        i_Byte_Valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bs[$], input int max_gap);
        foreach (bs[i]) send_byte(bs[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        while (o_Done !== 1'b1 && t < budget) begin
            @(negedge i_CLK);
            t++;
        end
        check(name, 32'(o_Done), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},   32'(o_Byte_Ready), 32'd0);
        check({tag, "_addr"},    32'(o_InstrMEM_Write_Addr), 32'd0);
        check({tag, "_instr"},   o_InstrMEM_Write_Instr, 32'd0);
        check({tag, "_memwr"},   32'(o_InstrMEM_MemWrite), 32'd0);
        check({tag, "_cpurstn"}, 32'(o_CPU_RSTN), 32'd0);
        check({tag, "_busy"},    32'(o_Busy), 32'd0);
        check({tag, "_done"},    32'(o_Done), 32'd0);
        check({tag, "_error"},   32'(o_Error), 32'd0);
    endtask

    // Two-word program: 0x00000013 @0, 0x00100093 @1; header+payload XOR is 0x92.
    task automatic run_two_word(input string tag, input int max_gap, input logic [7:0] chk, input logic exp_err);
        logic [7:0] bs[$];
        int w0;
        bs = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        bs.push_back(chk);
`endif
        exp_q.push_back('{addr: 10'd0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 10'd1, data: 32'h0010_0093});
        w0 = writes_seen;
        pulse_start();
        check({tag, "_busy"},    32'(o_Busy), 32'd1);
        check({tag, "_rstn_lo"}, 32'(o_CPU_RSTN), 32'd0);
        send_stream(bs, max_gap);
        wait_done({tag, "_done"}, 20);
        check({tag, "_cpurstn"}, 32'(o_CPU_RSTN), 32'd1);
        check({tag, "_error"},   32'(o_Error), 32'(exp_err));
        check({tag, "_busy_lo"}, 32'(o_Busy), 32'd0);
        check({tag, "_nwrites"}, 32'(writes_seen - w0), 32'd2);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] bs[$];
        logic [31:0] w;
        int w0;

        i_RST        = 1'b1;
        i_Start      = 1'b0;
        i_Byte       = 8'h00;
        i_Byte_Valid = 1'b0;
        repeat (3) @(negedge i_CLK);
        check_idle_outputs("reset");
        i_RST = 1'b0;

        // Basic two-word load.
        run_two_word("load", 0, 8'h92, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Same data with a wrong checksum byte.
        run_two_word("badchk", 0, 8'h00, 1'b1);
`endif

        // Zero-length load: no writes, DONE right after the length header.
        w0 = writes_seen;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(negedge i_CLK);
        check("zero_done",    32'(o_Done), 32'd1);
        check("zero_cpurstn", 32'(o_CPU_RSTN), 32'd1);
        check("zero_error",   32'(o_Error), 32'd0);
        check("zero_nwrites", 32'(writes_seen - w0), 32'd0);

        // Oversized count 0x0801 = 2049: clamped to 1024 words, error set.
        bs = '{8'h01, 8'h08};
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC0DE_0000 | 32'(i);
            bs.push_back(w[7:0]);
            bs.push_back(w[15:8]);
            bs.push_back(w[23:16]);
            bs.push_back(w[31:24]);
            exp_q.push_back('{addr: 10'(i), data: w});
        end
`ifdef LOADER_CHECKSUM_EN
        bs.push_back(8'h00);
`endif
        w0 = writes_seen;
        pulse_start();
        send_stream(bs, 0);
        wait_done("clamp_done", 20);
        check("clamp_error",    32'(o_Error), 32'd1);
        check("clamp_nwrites",  32'(writes_seen - w0), 32'd1024);
        check("clamp_lastaddr", 32'(o_InstrMEM_Write_Addr), 32'd1023);
        check("clamp_ready_lo", 32'(o_Byte_Ready), 32'd0);
        check("clamp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-word: everything clears, next load starts from address 0.
        w0 = writes_seen;
        pulse_start();
        bs = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        send_stream(bs, 0);
        #2;
        i_RST = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge i_CLK);
        i_RST = 1'b0;
        check("midrst_nwrites", 32'(writes_seen - w0), 32'd0);
        run_two_word("after_rst", 0, 8'h92, 1'b0);

        // Random valid gaps must not change the outcome.
        run_two_word("gaps", 7, 8'h92, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
